// File: rtl/light_latency_meter.sv
// light_latency_meter
// Debounces the synchronized photo-sensor level and measures the number of
// clk cycles from an accepted test-flash start to debounced light, or
// reports a timeout if no light arrives within TIMEOUT_CYCLES.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; start while light=1 is rejected
// MEASURE | counting cycles since start, watching for debounced light
// REPORT  | result/result_timeout freshly captured, result_valid high
//
// The reported latency includes the DEBOUNCE_CYCLES filter delay; the
// consumer is expected to subtract it.
module light_latency_meter #(
   parameter int COUNT_WIDTH     = 32,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 2**24
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   on,
   input  logic                   start,
   output logic                   light,
   output logic                   busy,
   output logic                   start_rejected,
   output logic [COUNT_WIDTH-1:0] result,
   output logic                   result_timeout,
   output logic                   result_valid
);

   // db_cnt only has to reach DEBOUNCE_CYCLES-1; keep at least one bit so
   // DEBOUNCE_CYCLES=1 still elaborates.
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0]        DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      REPORT  = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [DB_W-1:0]        db_cnt;
   logic [COUNT_WIDTH-1:0] cnt;
   logic [COUNT_WIDTH-1:0] cnt_next;
   logic [COUNT_WIDTH-1:0] result_next;
   logic                   result_timeout_next;
   logic                   start_rejected_next;

   // Debouncer: light follows on only after a mismatch persists
   // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         light  <= 1'b0;
         db_cnt <= '0;
      end else if (on == light) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         light  <= ~light;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + DB_W'(1);
      end
   end

   // FSM and measurement datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         result         <= '0;
         result_timeout <= 1'b0;
         start_rejected <= 1'b0;
      end else begin
         state          <= state_next;
         cnt            <= cnt_next;
         result         <= result_next;
         result_timeout <= result_timeout_next;
         start_rejected <= start_rejected_next;
      end
   end

   // Next-state, counter and capture logic. Light is tested before the
   // timeout compare so light arriving on the last counted cycle is a
   // valid measurement. cnt stops at TIMEOUT_VAL, so it cannot wrap.
   always_comb begin
      state_next          = state;
      cnt_next            = cnt;
      result_next         = result;
      result_timeout_next = result_timeout;
      start_rejected_next = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (!light) begin
                  state_next = MEASURE;
                  cnt_next   = CNT_ONE;
               end else begin
                  start_rejected_next = 1'b1;
               end
            end
         end
         MEASURE: begin
            start_rejected_next = start;
            if (light) begin
               result_next         = cnt;
               result_timeout_next = 1'b0;
               state_next          = REPORT;
            end else if (cnt == TIMEOUT_VAL) begin
               result_next         = TIMEOUT_VAL;
               result_timeout_next = 1'b1;
               state_next          = REPORT;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end
         REPORT: begin
            start_rejected_next = start;
            state_next          = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Status outputs decoded straight from the state register.
   always_comb begin
      busy         = 1'b0;
      result_valid = 1'b0;
      if (state != IDLE) busy = 1'b1;
      if (state == REPORT) result_valid = 1'b1;
   end

endmodule

// File: doc/light_latency_meter.md
# light_latency_meter

Consumes the synchronized photo-sensor level from the light-sensor stage. Debounces it and measures, in `clk` cycles, the time from a test-flash trigger to detected light on the monitored display. Sits directly downstream of the sensor synchronizer. Reports one result per trigger to the delay-calibration logic, either a latency count or a timeout.

## Interface
- `COUNT_WIDTH`, 32: width of the latency counter and `result`.
- `DEBOUNCE_CYCLES`, 16: consecutive cycles a new sensor level must persist before `light` follows it; ≥1.
- `TIMEOUT_CYCLES`, 2**24: maximum measured latency; must be < 2**COUNT_WIDTH and > DEBOUNCE_CYCLES.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `on`  in  1  sensor level, already 2-FF synchronized to `clk`.
- `start`  in  1  single-cycle pulse: test flash emitted this cycle.
- `light`  out  1  debounced sensor level.
- `busy`  out  1  measurement in progress (MEASURE or REPORT).
- `start_rejected`  out  1  one-cycle pulse: a `start` was dropped.
- `result`  out  COUNT_WIDTH  last latency in cycles; held until next report.
- `result_timeout`  out  1  qualifies `result`; 1 = no light within TIMEOUT_CYCLES.
- `result_valid`  out  1  one-cycle pulse: `result`/`result_timeout` updated.

## Operation
- Debouncer:
  - Counter `db_cnt` clears whenever `on == light`.
  - It increments each cycle `on != light`.
  - When `on != light` and `db_cnt == DEBOUNCE_CYCLES-1`, `light` toggles at the next edge and `db_cnt` clears.
  - A mismatch lasting fewer than DEBOUNCE_CYCLES cycles never changes `light`.
- FSM states IDLE, MEASURE, REPORT. Reset state IDLE.
- IDLE:
  - `start=1` and `light=0`: go to MEASURE and load `cnt <= 1`.
  - `start=1` and `light=1`: stay IDLE and pulse `start_rejected` next cycle.
- MEASURE:
  - `light=1`: capture `result <= cnt` and `result_timeout <= 0`, then go to REPORT.
  - Else, if `cnt == TIMEOUT_CYCLES`: capture `result <= TIMEOUT_CYCLES` and `result_timeout <= 1`, then go to REPORT.
  - Else `cnt <= cnt + 1`.
  - `light=1` on the timeout cycle counts as a valid measurement; light wins.
- REPORT: `result_valid=1` for exactly this cycle, then go to IDLE unconditionally.
- `start` in MEASURE or REPORT is dropped and pulses `start_rejected` next cycle. It never restarts the measurement.
- The reported latency includes the debounce delay of DEBOUNCE_CYCLES. The block does not compensate; consumers subtract.
- `cnt` never exceeds TIMEOUT_CYCLES, so no wrap is possible.

## Timing
- Reset values:
  - `light=0`, `busy=0`, `start_rejected=0`, `result=0`, `result_timeout=0`, `result_valid=0`.
  - State IDLE; `db_cnt=0`; `cnt=0`.
- Reset asserted mid-measurement aborts it immediately. No `result_valid` is produced for the aborted measurement, and `result` returns to 0.
- Debounce latency: with `on` rising at cycle k and held, `light=1` at cycle k+DEBOUNCE_CYCLES.
- Measurement timeline, with `start` accepted at cycle 0:
  - Cycle 1: MEASURE, `busy=1`, `cnt=1`.
  - `light` first 1 at cycle N: `result=N` and `result_valid=1` at cycle N+1.
  - Cycle N+2: IDLE, `busy=0`.
  - A new `start` is accepted from cycle N+2.
- Timeout: with no light, `result_valid=1`, `result=TIMEOUT_CYCLES` and `result_timeout=1` at cycle TIMEOUT_CYCLES+1.
- `start_rejected` is registered and asserts the cycle after the dropped `start`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=100.
- Basic: `start` at cycle 0, `on` rises at cycle 10 and holds → `light=1` at cycle 14; `result_valid` at cycle 15 with `result=14`, `result_timeout=0`; `busy` deasserts at cycle 16.
- Glitch: `on` high for 3 cycles at cycle 5, then high from cycle 20 → `light` stays 0 through the glitch; `result=24`.
- Timeout: `start` with `on` held 0 → `result_valid` at cycle 101 with `result=100`, `result_timeout=1`.
- Boundary: `on` rises at cycle 96, so `light=1` exactly at `cnt=100` → `result=100`, `result_timeout=0`.
- Rejection: `start` while `light=1` → `start_rejected` pulse next cycle, `busy` stays 0. A second `start` during MEASURE → `start_rejected` pulse, and the original measurement completes unchanged.
- Reset mid-op: assert `reset` at cycle 7 of a measurement → all outputs return to reset values with no `result_valid`. A later `start` then measures correctly from scratch.
